// File: rtl/rv32i_defs.sv
// rtl/rv32i_defs.sv - shared rv32i core constants
package rv32i_defs;

    localparam int RegisterSize = 5;
    localparam int OperandSize  = 32;
    localparam int NumRegisters = 32;
    localparam int SpIndex      = 2;
    localparam int SpResetValue = 255;

endpackage

// File: rtl/rv_scoreboard.sv
// rtl/rv_scoreboard.sv - per-register busy bits with issue-over-writeback priority
import rv32i_defs::*;

module rv_scoreboard #(
    parameter int NUM_REGS = NumRegisters,
    parameter int AW       = RegisterSize,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_RD*AW-1:0] i_rd_addr,
    input  logic [NUM_WR-1:0]    i_wr_en,
    input  logic [NUM_WR*AW-1:0] i_wr_addr,
    input  logic                 i_iss_valid,
    input  logic [AW-1:0]        i_iss_addr,
    output logic [NUM_RD-1:0]    o_rd_busy,
    output logic                 o_iss_waw
);

    logic [NUM_REGS-1:0] r_busy;
    logic [NUM_REGS-1:0] w_busy_d;

    // Clears are applied first so a same-cycle issue overrides them.
    always_comb begin
        w_busy_d = r_busy;
        for (int r = 1; r < NUM_REGS; r++) begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (i_wr_en[j] && i_wr_addr[j*AW +: AW] == AW'(r)) begin
                    w_busy_d[r] = 1'b0;
                end
            end
            if (i_iss_valid && i_iss_addr == AW'(r)) begin
                w_busy_d[r] = 1'b1;
            end
        end
        w_busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_d;
        end
    end

    always_comb begin
        o_rd_busy = '0;
        o_iss_waw = 1'b0;
        for (int i = 0; i < NUM_RD; i++) begin
            logic [AW-1:0] w_a;
            w_a = i_rd_addr[i*AW +: AW];
            if (w_a != '0 && int'(w_a) < NUM_REGS) begin
                o_rd_busy[i] = r_busy[w_a];
            end
        end
        if (i_iss_valid && i_iss_addr != '0 && int'(i_iss_addr) < NUM_REGS) begin
            o_iss_waw = r_busy[i_iss_addr];
        end
    end

endmodule

// File: rtl/rv_regfile_mp.sv
// rtl/rv_regfile_mp.sv - multi-port rv32i register file with bypass and busy scoreboard
import rv32i_defs::*;

module rv_regfile_mp #(
    parameter int XLEN     = OperandSize,
    parameter int NUM_REGS = NumRegisters,
    parameter int AW       = RegisterSize,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    parameter int BYPASS   = 1,
    parameter int SP_IDX   = SpIndex,
    parameter int SP_RESET = SpResetValue
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_RD*AW-1:0]   i_rd_addr,
    output logic [NUM_RD*XLEN-1:0] o_rd_data,
    output logic [NUM_RD-1:0]      o_rd_busy,
    input  logic [NUM_WR-1:0]      i_wr_en,
    input  logic [NUM_WR*AW-1:0]   i_wr_addr,
    input  logic [NUM_WR*XLEN-1:0] i_wr_data,
    input  logic                   i_iss_valid,
    input  logic [AW-1:0]          i_iss_addr,
    output logic                   o_iss_waw
);

    logic [XLEN-1:0]   r_mem [NUM_REGS];
    logic [NUM_RD-1:0] w_sb_busy;

    rv_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .AW       (AW),
        .NUM_RD   (NUM_RD),
        .NUM_WR   (NUM_WR)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .i_rd_addr   (i_rd_addr),
        .i_wr_en     (i_wr_en),
        .i_wr_addr   (i_wr_addr),
        .i_iss_valid (i_iss_valid),
        .i_iss_addr  (i_iss_addr),
        .o_rd_busy   (w_sb_busy),
        .o_iss_waw   (o_iss_waw)
    );

    // Later ports' assignments land last, so the highest index wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_mem[r] <= (r == SP_IDX) ? XLEN'(SP_RESET) : '0;
            end
        end else begin
            for (int r = 1; r < NUM_REGS; r++) begin
                for (int j = 0; j < NUM_WR; j++) begin
                    if (i_wr_en[j] && i_wr_addr[j*AW +: AW] == AW'(r)) begin
                        r_mem[r] <= i_wr_data[j*XLEN +: XLEN];
                    end
                end
            end
        end
    end

    always_comb begin
        o_rd_data = '0;
        o_rd_busy = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            logic [AW-1:0] w_a;
            w_a = i_rd_addr[i*AW +: AW];
            if (w_a != '0 && int'(w_a) < NUM_REGS) begin
                o_rd_data[i*XLEN +: XLEN] = r_mem[w_a];
                o_rd_busy[i]              = w_sb_busy[i];
                if (BYPASS != 0) begin
                    for (int j = 0; j < NUM_WR; j++) begin
                        if (i_wr_en[j] && i_wr_addr[j*AW +: AW] == w_a) begin
                            o_rd_data[i*XLEN +: XLEN] = i_wr_data[j*XLEN +: XLEN];
                            o_rd_busy[i]              = i_iss_valid && i_iss_addr == w_a;
                        end
                    end
                end
            end
        end
    end

endmodule
